// File: rtl/mtc_builder_matcher.sv
// -----------------------------------------------------------------------------
// mtc_builder_matcher
//
// Buffers sector-logic (SL) pipeline candidates per primary MTC channel and
// matches each incoming pT-calc result to its buffered candidate by tag. It
// emits one registered MTC word per channel per cycle. Unmatched candidates
// are flushed with a timeout flag once they reach TIMEOUT_CYCLES of age.
//
// Ports:
//   clock       - single clock
//   rst         - synchronous, active-low reset
//   ptcalc      - c_NUM_THREADS pT-calc words; thread k at [k*PTCALC_WIDTH +: PTCALC_WIDTH]
//   sl          - n_PRIMARY_MTC SL words; channel i at [i*SLCPIPELINE_WIDTH +: SLCPIPELINE_WIDTH]
//   mtc         - n_PRIMARY_MTC output words; channel i at [i*MTC2SL_LEN +: MTC2SL_LEN]
//                 {valid, timeout, pT payload, SL payload}, unused bits 0
//   occupancy   - valid slot count per channel, registered
//   ovf_cnt     - SL words dropped on a full channel (saturating)
//   nomatch_cnt - valid pT-calc words with no matching tag (saturating)
//   drop_cnt    - matched pT-calc words that lost channel arbitration (saturating)
// -----------------------------------------------------------------------------
module mtc_builder_matcher #(
    parameter int PTCALC_WIDTH      = 16,
    parameter int SLCPIPELINE_WIDTH = 16,
    parameter int MTC2SL_LEN        = 32,
    parameter int c_NUM_THREADS     = 3,
    parameter int n_PRIMARY_MTC     = 3,
    parameter int c_BUF_DEPTH       = 4,
    parameter int TAG_WIDTH         = 8,
    parameter int TIMEOUT_CYCLES    = 64,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                       clock,
    input  logic                                       rst,
    input  logic [PTCALC_WIDTH*c_NUM_THREADS-1:0]      ptcalc,
    input  logic [SLCPIPELINE_WIDTH*n_PRIMARY_MTC-1:0] sl,
    output logic [MTC2SL_LEN*n_PRIMARY_MTC-1:0]        mtc,
    output logic [n_PRIMARY_MTC*$clog2(c_BUF_DEPTH+1)-1:0] occupancy,
    output logic [CNT_WIDTH-1:0]                       ovf_cnt,
    output logic [CNT_WIDTH-1:0]                       nomatch_cnt,
    output logic [CNT_WIDTH-1:0]                       drop_cnt
);

    localparam int OCC_W = $clog2(c_BUF_DEPTH + 1);
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SL_PW = SLCPIPELINE_WIDTH - 1;
    localparam int PT_PW = PTCALC_WIDTH - 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

    // Slot state
    logic [c_BUF_DEPTH-1:0] slot_valid_q [n_PRIMARY_MTC];
    logic [c_BUF_DEPTH-1:0] slot_valid_d [n_PRIMARY_MTC];
    logic [AGE_W-1:0]       slot_age_q   [n_PRIMARY_MTC][c_BUF_DEPTH];
    logic [AGE_W-1:0]       slot_age_d   [n_PRIMARY_MTC][c_BUF_DEPTH];
    logic [SL_PW-1:0]       slot_data_q  [n_PRIMARY_MTC][c_BUF_DEPTH];
    logic [SL_PW-1:0]       slot_data_d  [n_PRIMARY_MTC][c_BUF_DEPTH];

    // Registered outputs
    logic [MTC2SL_LEN-1:0] mtc_ch_q [n_PRIMARY_MTC];
    logic [MTC2SL_LEN-1:0] mtc_ch_d [n_PRIMARY_MTC];
    logic [OCC_W-1:0]      occ_q    [n_PRIMARY_MTC];
    logic [OCC_W-1:0]      occ_d    [n_PRIMARY_MTC];
    logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [CNT_WIDTH-1:0]  nomatch_cnt_q, nomatch_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    // Combinational working state
    logic        thr_hit  [c_NUM_THREADS];
    int unsigned thr_ch   [c_NUM_THREADS];
    int unsigned thr_slot [c_NUM_THREADS];
    logic        ch_busy  [n_PRIMARY_MTC];
    logic [7:0]  ovf_inc, nomatch_inc, drop_inc;
    logic        found;
    logic [MTC2SL_LEN-1:0] word;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                      input logic [7:0]           inc);
        logic [CNT_WIDTH+8:0] s;
        s = {9'b0, c} + {{(CNT_WIDTH+1){1'b0}}, inc};
        if (s > {9'b0, {CNT_WIDTH{1'b1}}}) return '1;
        return s[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_age_d   = slot_age_q;
        slot_data_d  = slot_data_q;
        ovf_inc      = '0;
        nomatch_inc  = '0;
        drop_inc     = '0;
        found        = 1'b0;
        word         = '0;
        for (int unsigned i = 0; i < n_PRIMARY_MTC; i++) begin
            mtc_ch_d[i] = '0;
            ch_busy[i]  = 1'b0;
            occ_d[i]    = '0;
        end
        for (int unsigned k = 0; k < c_NUM_THREADS; k++) begin
            thr_hit[k]  = 1'b0;
            thr_ch[k]   = 0;
            thr_slot[k] = 0;
        end

        // Ageing of occupied slots, saturating at the timeout value
        for (int unsigned i = 0; i < n_PRIMARY_MTC; i++)
            for (int unsigned j = 0; j < c_BUF_DEPTH; j++)
                if (slot_valid_q[i][j] && slot_age_q[i][j] != AGE_MAX)
                    slot_age_d[i][j] = slot_age_q[i][j] + AGE_W'(1);

        // Tag search against registered slots only, so a candidate written
        // this cycle is invisible; scan order gives lowest channel, then slot.
        for (int unsigned k = 0; k < c_NUM_THREADS; k++) begin
            if (ptcalc[k*PTCALC_WIDTH + PTCALC_WIDTH - 1]) begin
                for (int unsigned i = 0; i < n_PRIMARY_MTC; i++)
                    for (int unsigned j = 0; j < c_BUF_DEPTH; j++)
                        if (!thr_hit[k] && slot_valid_q[i][j] &&
                            slot_data_q[i][j][TAG_WIDTH-1:0] ==
                            ptcalc[k*PTCALC_WIDTH +: TAG_WIDTH]) begin
                            thr_hit[k]  = 1'b1;
                            thr_ch[k]   = i;
                            thr_slot[k] = j;
                        end
                if (!thr_hit[k]) nomatch_inc = nomatch_inc + 8'd1;
            end
        end

        // Channel arbitration: lowest thread wins; losers keep their slot.
        // A second thread on an already-freed slot lands here too.
        for (int unsigned k = 0; k < c_NUM_THREADS; k++) begin
            if (thr_hit[k]) begin
                if (ch_busy[thr_ch[k]]) begin
                    drop_inc = drop_inc + 8'd1;
                end else begin
                    ch_busy[thr_ch[k]] = 1'b1;
                    word = '0;
                    word[MTC2SL_LEN-1]   = 1'b1;
                    word[SL_PW-1:0]      = slot_data_q[thr_ch[k]][thr_slot[k]];
                    word[SL_PW +: PT_PW] = ptcalc[k*PTCALC_WIDTH +: PT_PW];
                    mtc_ch_d[thr_ch[k]]  = word;
                    slot_valid_d[thr_ch[k]][thr_slot[k]] = 1'b0;
                    slot_age_d[thr_ch[k]][thr_slot[k]]   = '0;
                end
            end
        end

        // Timeout flush on channels without a match, one slot per cycle
        for (int unsigned i = 0; i < n_PRIMARY_MTC; i++) begin
            found = 1'b0;
            for (int unsigned j = 0; j < c_BUF_DEPTH; j++) begin
                if (!ch_busy[i] && !found && slot_valid_q[i][j] &&
                    slot_age_q[i][j] == AGE_MAX) begin
                    found = 1'b1;
                    word = '0;
                    word[MTC2SL_LEN-1] = 1'b1;
                    word[MTC2SL_LEN-2] = 1'b1;
                    word[SL_PW-1:0]    = slot_data_q[i][j];
                    mtc_ch_d[i]        = word;
                    slot_valid_d[i][j] = 1'b0;
                    slot_age_d[i][j]   = '0;
                end
            end
        end

        // SL write into lowest slot free at the start of the cycle; slots
        // freed this cycle are deliberately not considered.
        for (int unsigned i = 0; i < n_PRIMARY_MTC; i++) begin
            if (sl[i*SLCPIPELINE_WIDTH + SLCPIPELINE_WIDTH - 1]) begin
                found = 1'b0;
                for (int unsigned j = 0; j < c_BUF_DEPTH; j++) begin
                    if (!found && !slot_valid_q[i][j]) begin
                        found = 1'b1;
                        slot_valid_d[i][j] = 1'b1;
                        slot_age_d[i][j]   = '0;
                        slot_data_d[i][j]  = sl[i*SLCPIPELINE_WIDTH +: SL_PW];
                    end
                end
                if (!found) ovf_inc = ovf_inc + 8'd1;
            end
        end

        for (int unsigned i = 0; i < n_PRIMARY_MTC; i++)
            for (int unsigned j = 0; j < c_BUF_DEPTH; j++)
                occ_d[i] = occ_d[i] + OCC_W'(slot_valid_d[i][j]);

        ovf_cnt_d     = sat_add(ovf_cnt_q, ovf_inc);
        nomatch_cnt_d = sat_add(nomatch_cnt_q, nomatch_inc);
        drop_cnt_d    = sat_add(drop_cnt_q, drop_inc);
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            for (int unsigned i = 0; i < n_PRIMARY_MTC; i++) begin
                slot_valid_q[i] <= '0;
                mtc_ch_q[i]     <= '0;
                occ_q[i]        <= '0;
                for (int unsigned j = 0; j < c_BUF_DEPTH; j++)
                    slot_age_q[i][j] <= '0;
            end
            ovf_cnt_q     <= '0;
            nomatch_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            slot_valid_q  <= slot_valid_d;
            slot_age_q    <= slot_age_d;
            mtc_ch_q      <= mtc_ch_d;
            occ_q         <= occ_d;
            ovf_cnt_q     <= ovf_cnt_d;
            nomatch_cnt_q <= nomatch_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset: it is only read while its valid bit is set
    always_ff @(posedge clock) begin
        slot_data_q <= slot_data_d;
    end

    always_comb begin
        mtc       = '0;
        occupancy = '0;
        for (int unsigned i = 0; i < n_PRIMARY_MTC; i++) begin
            mtc[i*MTC2SL_LEN +: MTC2SL_LEN] = mtc_ch_q[i];
            occupancy[i*OCC_W +: OCC_W]     = occ_q[i];
        end
    end

    assign ovf_cnt     = ovf_cnt_q;
    assign nomatch_cnt = nomatch_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mtc_builder_matcher.sv
// -----------------------------------------------------------------------------
// tb_mtc_builder_matcher
//
// Directed bench for mtc_builder_matcher with 16-bit SL/pT words, 32-bit MTC
// words, 3 threads, 3 channels, depth 4, TIMEOUT_CYCLES=8 and 4-bit counters.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_mtc_builder_matcher;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic [47:0] ptcalc;
    logic [47:0] sl;
    logic [95:0] mtc;
    logic [8:0]  occupancy;
    logic [3:0]  ovf_cnt, nomatch_cnt, drop_cnt;

    logic [15:0] sl_w [3];
    logic [15:0] pt_w [3];
    logic [31:0] mtc_w [3];
    logic [2:0]  occ_w [3];

    int n_cmp = 0;
    int n_err = 0;

    assign sl     = {sl_w[2], sl_w[1], sl_w[0]};
    assign ptcalc = {pt_w[2], pt_w[1], pt_w[0]};
    assign mtc_w[0] = mtc[31:0];
    assign mtc_w[1] = mtc[63:32];
    assign mtc_w[2] = mtc[95:64];
    assign occ_w[0] = occupancy[2:0];
    assign occ_w[1] = occupancy[5:3];
    assign occ_w[2] = occupancy[8:6];

    always #5 clock = ~clock;

    mtc_builder_matcher #(
        .PTCALC_WIDTH(16), .SLCPIPELINE_WIDTH(16), .MTC2SL_LEN(32),
        .c_NUM_THREADS(3), .n_PRIMARY_MTC(3), .c_BUF_DEPTH(4),
        .TAG_WIDTH(8), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)
    ) dut (
        .clock(clock), .rst(rst), .ptcalc(ptcalc), .sl(sl), .mtc(mtc),
        .occupancy(occupancy), .ovf_cnt(ovf_cnt), .nomatch_cnt(nomatch_cnt),
        .drop_cnt(drop_cnt)
    );

    function automatic logic [15:0] mk(input logic [7:0] tag, input logic [6:0] hi);
        return {1'b1, hi, tag};
    endfunction

    function automatic logic [31:0] exp_w(input logic to, input logic [15:0] slw,
                                          input logic [15:0] ptw);
        return {1'b1, to, ptw[14:0], slw[14:0]};
    endfunction

    task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in;
        for (int i = 0; i < 3; i++) begin
            sl_w[i] = '0;
            pt_w[i] = '0;
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        idle_in();

        // Reset state
        tick();
        chk("rst_mtc", mtc, '0);
        chk("rst_occ", {87'b0, occupancy}, '0);
        chk("rst_cnt", {84'b0, ovf_cnt, nomatch_cnt, drop_cnt}, '0);
        rst = 1'b1;

        // Basic match: ch1 tag 0x12 at t0, thread2 at t3, output at t4
        sl_w[1] = mk(8'h12, 7'h11);
        tick();
        idle_in();
        chk("basic_occ1", {93'b0, occ_w[1]}, 96'd1);
        chk("basic_idle", mtc, '0);
        tick();
        tick();
        pt_w[2] = mk(8'h12, 7'h22);
        tick();
        idle_in();
        chk("basic_mtc1", {64'b0, mtc_w[1]}, {64'b0, exp_w(1'b0, mk(8'h12, 7'h11), mk(8'h12, 7'h22))});
        chk("basic_mtc0", {64'b0, mtc_w[0]}, '0);
        chk("basic_occ1_free", {93'b0, occ_w[1]}, '0);
        chk("basic_cnt", {84'b0, ovf_cnt, nomatch_cnt, drop_cnt}, '0);
        tick();
        chk("basic_after", mtc, '0);

        // Same-cycle SL and pT: not yet visible -> nomatch, then matches next cycle
        sl_w[0] = mk(8'h30, 7'h01);
        pt_w[0] = mk(8'h30, 7'h02);
        tick();
        sl_w[0] = '0;
        chk("vis_nomatch", {92'b0, nomatch_cnt}, 96'd1);
        chk("vis_mtc", mtc, '0);
        tick();
        pt_w[0] = '0;
        chk("vis_match", {64'b0, mtc_w[0]}, {64'b0, exp_w(1'b0, mk(8'h30, 7'h01), mk(8'h30, 7'h02))});

        // Timeout: flush becomes visible TO+1 edges after the write edge
        sl_w[0] = mk(8'h05, 7'h15);
        tick();
        sl_w[0] = '0;
        repeat (TO) tick();
        chk("to_early", {64'b0, mtc_w[0]}, '0);
        chk("to_occ_held", {93'b0, occ_w[0]}, 96'd1);
        tick();
        chk("to_flush", {64'b0, mtc_w[0]}, {64'b0, exp_w(1'b1, mk(8'h05, 7'h15), 16'h0)});
        chk("to_occ0", {93'b0, occ_w[0]}, '0);
        tick();
        chk("to_after", mtc, '0);

        // Overflow: five SL words into ch2 (depth 4)
        for (int i = 0; i < 5; i++) begin
            sl_w[2] = mk(8'h40 + 8'(i), 7'h40);
            tick();
        end
        sl_w[2] = '0;
        chk("ovf_occ2", {93'b0, occ_w[2]}, 96'd4);
        chk("ovf_cnt", {92'b0, ovf_cnt}, 96'd1);
        pt_w[1] = mk(8'h44, 7'h33);
        tick();
        pt_w[1] = '0;
        chk("ovf_nomatch", {92'b0, nomatch_cnt}, 96'd2);
        chk("ovf_mtc", mtc, '0);
        do_reset();

        // Arbitration: two threads hitting ch0 in the same cycle
        sl_w[0] = mk(8'h0A, 7'h0A);
        tick();
        sl_w[0] = mk(8'h0B, 7'h0B);
        tick();
        sl_w[0] = '0;
        pt_w[0] = mk(8'h0A, 7'h5A);
        pt_w[1] = mk(8'h0B, 7'h5B);
        tick();
        idle_in();
        chk("arb_win", {64'b0, mtc_w[0]}, {64'b0, exp_w(1'b0, mk(8'h0A, 7'h0A), mk(8'h0A, 7'h5A))});
        chk("arb_drop", {92'b0, drop_cnt}, 96'd1);
        chk("arb_occ0", {93'b0, occ_w[0]}, 96'd1);
        pt_w[2] = mk(8'h0B, 7'h6B);
        tick();
        pt_w[2] = '0;
        chk("arb_retry", {64'b0, mtc_w[0]}, {64'b0, exp_w(1'b0, mk(8'h0B, 7'h0B), mk(8'h0B, 7'h6B))});
        chk("arb_occ0_free", {93'b0, occ_w[0]}, '0);
        chk("arb_drop_hold", {92'b0, drop_cnt}, 96'd1);

        // Same tag in ch1 and ch2: lowest channel wins
        sl_w[1] = mk(8'h50, 7'h01);
        sl_w[2] = mk(8'h50, 7'h02);
        tick();
        idle_in();
        pt_w[0] = mk(8'h50, 7'h03);
        tick();
        pt_w[0] = '0;
        chk("lowch_mtc1", {64'b0, mtc_w[1]}, {64'b0, exp_w(1'b0, mk(8'h50, 7'h01), mk(8'h50, 7'h03))});
        chk("lowch_mtc2", {64'b0, mtc_w[2]}, '0);
        chk("lowch_occ2", {93'b0, occ_w[2]}, 96'd1);
        do_reset();
        chk("rst2_occ", {87'b0, occupancy}, '0);
        chk("rst2_cnt", {84'b0, ovf_cnt, nomatch_cnt, drop_cnt}, '0);

        // Reset mid-operation with a match in flight
        sl_w[1] = mk(8'h60, 7'h10);
        tick();
        sl_w[1] = mk(8'h61, 7'h11);
        tick();
        sl_w[1] = '0;
        pt_w[0] = mk(8'h60, 7'h12);
        pt_w[1] = mk(8'h99, 7'h13);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_in();
        chk("mrst_mtc", mtc, '0);
        chk("mrst_occ", {87'b0, occupancy}, '0);
        chk("mrst_cnt", {84'b0, ovf_cnt, nomatch_cnt, drop_cnt}, '0);
        tick();
        chk("mrst_no_late", mtc, '0);
        pt_w[0] = mk(8'h61, 7'h14);
        tick();
        pt_w[0] = '0;
        chk("mrst_cleared", {92'b0, nomatch_cnt}, 96'd1);
        chk("mrst_mtc2", mtc, '0);

        // Multiple nomatches in one cycle, then saturation
        do_reset();
        pt_w[0] = mk(8'hE0, 7'h0);
        pt_w[1] = mk(8'hE1, 7'h0);
        pt_w[2] = mk(8'hE2, 7'h0);
        tick();
        pt_w[1] = '0;
        pt_w[2] = '0;
        chk("multi_nomatch", {92'b0, nomatch_cnt}, 96'd3);
        for (int i = 0; i < 20; i++) tick();
        pt_w[0] = '0;
        chk("sat_nomatch", {92'b0, nomatch_cnt}, 96'd15);
        tick();
        chk("sat_hold", {92'b0, nomatch_cnt}, 96'd15);
        chk("sat_others", {88'b0, ovf_cnt, drop_cnt}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
